// File: rtl/defs.sv
// rtl/defs.sv - shared state encoding and constants for the program sequencer
package defs;

    typedef enum logic [1:0] {
        RST_SYNC = 2'd0,
        RST_HOLD = 2'd1,
        RUN      = 2'd2
    } seq_state_t;

    localparam logic [7:0] PM_RESET_ADDR = 8'h00;

endpackage

// File: rtl/reset_synchronizer.sv
// rtl/reset_synchronizer.sv - stretches reset release into a two-cycle synchronous reset
import defs::*;

module reset_synchronizer (
    input  logic clk,
    input  logic reset_n,
    output logic sync_reset
);

    seq_state_t state_q;
    seq_state_t state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST_SYNC: state_d = RST_HOLD;
            RST_HOLD: state_d = RUN;
            RUN:      state_d = RUN;
            default:  state_d = RST_SYNC;
        endcase
    end

    // Driven only from the state register so reset_n has no combinational path here.
    assign sync_reset = (state_q != RUN);

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - next-address logic and pc; PS_JUMP_COUNT_EN adds a jump counter on from_PS
import defs::*;

module program_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       jmp,
    input  logic       jmp_nz,
    input  logic [3:0] ir_nibble,
    input  logic       dont_jmp,
    input  logic       hold,
    output logic       sync_reset,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic [7:0] from_PS
);

    logic [7:0] pc_q;
    logic [7:0] pc_d;
    logic       jump_taken;

    reset_synchronizer u_reset_synchronizer (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset)
    );

    // Jumps never carry into the page bits.
    always_comb begin
        jump_taken = 1'b0;
        pm_addr    = pc_q + 8'd1;
        if (sync_reset) begin
            pm_addr = PM_RESET_ADDR;
        end else if (hold) begin
            pm_addr = pc_q;
        end else if (jmp || (jmp_nz && !dont_jmp)) begin
            jump_taken = 1'b1;
            pm_addr    = {pc_q[7:4], ir_nibble};
        end
    end

    always_comb begin
        pc_d = pm_addr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= PM_RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

`ifdef PS_JUMP_COUNT_EN
    logic [7:0] jump_cnt_q;
    logic [7:0] jump_cnt_d;

    always_comb begin
        jump_cnt_d = jump_cnt_q;
        if (jump_taken && (jump_cnt_q != 8'hFF)) begin
            jump_cnt_d = jump_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jump_cnt_q <= 8'h00;
        end else begin
            jump_cnt_q <= jump_cnt_d;
        end
    end

    assign from_PS = jump_cnt_q;
`else
    logic unused_jump_taken;
    assign unused_jump_taken = jump_taken;
    assign from_PS = 8'h00;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed scoreboard bench for program_sequencer
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       jmp = 1'b0;
    logic       jmp_nz = 1'b0;
    logic [3:0] ir_nibble = 4'h0;
    logic       dont_jmp = 1'b0;
    logic       hold = 1'b0;
    logic       sync_reset;
    logic [7:0] pm_addr;
    logic [7:0] pc;
    logic [7:0] from_PS;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mpc = 8'h00;
    logic [7:0] mcnt = 8'h00;

    program_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .ir_nibble  (ir_nibble),
        .dont_jmp   (dont_jmp),
        .hold       (hold),
        .sync_reset (sync_reset),
        .pm_addr    (pm_addr),
        .pc         (pc),
        .from_PS    (from_PS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic model_taken();
        return !hold && (jmp || (jmp_nz && !dont_jmp));
    endfunction

    function automatic logic [7:0] model_next();
        if (hold) return mpc;
        if (jmp || (jmp_nz && !dont_jmp)) return {mpc[7:4], ir_nibble};
        return mpc + 8'd1;
    endfunction

    // One RUN-state cycle: predict, push, clock, pop and compare.
    task automatic step(input string tag);
        logic [7:0] e;
        e = model_next();
        exp_q.push_back(e);
        if (model_taken() && mcnt != 8'hFF) mcnt = mcnt + 8'd1;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            chk(tag, pc, exp_q.pop_front());
        end
        mpc = e;
    endtask

    task automatic run_to(input logic [7:0] target);
        for (int i = 0; i < 256 && mpc != target; i++) step("inc");
    endtask

    task automatic check_cnt(input string tag);
`ifdef PS_JUMP_COUNT_EN
        chk(tag, from_PS, mcnt);
`else
        chk(tag, from_PS, 8'h00);
`endif
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        jmp = 1'b1;
        ir_nibble = 4'h5;
        hold = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_e1_sync", {7'd0, sync_reset}, 8'h01);
        chk("rel_e1_pc", pc, 8'h00);
        chk("rel_e1_pm", pm_addr, 8'h00);
        @(posedge clk);
        #1;
        chk("rel_e2_sync", {7'd0, sync_reset}, 8'h00);
        chk("rel_e2_pc", pc, 8'h00);
        jmp = 1'b0;
        hold = 1'b0;
        mpc = 8'h00;
        mcnt = 8'h00;
    endtask

    initial begin
        #3;
        chk("rst_pc", pc, 8'h00);
        chk("rst_sync", {7'd0, sync_reset}, 8'h01);
        chk("rst_pm", pm_addr, 8'h00);
        chk("rst_from_ps", from_PS, 8'h00);

        release_reset();
        step("adv01");
        step("adv02");

        run_to(8'h37);
        jmp = 1'b1; ir_nibble = 4'hA;
        #1 chk("jmp_pm_comb", pm_addr, 8'h3A);
        step("jmp_3a");
        jmp = 1'b0;
        check_cnt("cnt_after_jmp");

        run_to(8'h50);
        jmp_nz = 1'b1; ir_nibble = 4'h2; dont_jmp = 1'b1;
        step("jnz_suppressed");
        check_cnt("cnt_jnz_suppressed");
        jmp_nz = 1'b0; jmp = 1'b1; ir_nibble = 4'h0;
        step("back_to_50");
        jmp = 1'b0; jmp_nz = 1'b1; ir_nibble = 4'h2; dont_jmp = 1'b0;
        step("jnz_taken");
        jmp = 1'b1; jmp_nz = 1'b1; dont_jmp = 1'b1; ir_nibble = 4'hC;
        step("jmp_beats_jnz");
        jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;

        run_to(8'hFF);
        #1 chk("wrap_pm", pm_addr, 8'h00);
        step("wrap_00");

        run_to(8'h10);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) step("hold_10");
        hold = 1'b0;
        step("hold_drop_11");
        hold = 1'b1; jmp = 1'b1; ir_nibble = 4'h7;
        step("hold_beats_jmp");
        check_cnt("cnt_hold_jmp");
        hold = 1'b0;
        step("jmp_after_hold");
        jmp = 1'b0;
        check_cnt("cnt_after_hold");

        run_to(8'h44);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_pc", pc, 8'h00);
        chk("midrst_sync", {7'd0, sync_reset}, 8'h01);
        chk("midrst_pm", pm_addr, 8'h00);
        chk("midrst_from_ps", from_PS, 8'h00);
        exp_q.delete();
        #12;
        release_reset();
        step("post_rst_01");

`ifdef PS_JUMP_COUNT_EN
        jmp = 1'b1; ir_nibble = 4'h3;
        for (int i = 0; i < 300; i++) step("jmp_many");
        jmp = 1'b0;
        chk("cnt_saturated", from_PS, 8'hFF);
        step("after_sat");
        chk("cnt_still_ff", from_PS, 8'hFF);
`endif
        check_cnt("cnt_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
